// File: rtl/viterbi_acs4_if.sv
// Symbol/result bundle between the branch-metric source, the ACS stage and the traceback unit.
interface viterbi_acs4_if #(
  parameter int W = 6
);
  logic           in_valid;
  logic           start;
  logic [1:0]     sym;
  logic           out_valid;
  logic [3:0]     dec;
  logic [1:0]     min_state;
  logic [4*W-1:0] pm;

  modport master (
    output in_valid, start, sym,
    input  out_valid, dec, min_state, pm
  );

  modport slave (
    input  in_valid, start, sym,
    output out_valid, dec, min_state, pm
  );
endinterface

// File: rtl/viterbi_acs4.sv
// Four-state add-compare-select stage for the K=3 (7,5) Viterbi decoder with
// saturating path metrics and per-step min normalization.
module viterbi_acs4 #(
  parameter int W       = 6,
  parameter int INIT_PM = 16
) (
  input logic           clk,
  input logic           rst_n,
  viterbi_acs4_if.slave bus
);
  localparam logic signed [W:0]   SUM_MAX  = (W+1)'(2**(W-1) - 1);
  localparam logic signed [W:0]   SUM_MIN  = (W+1)'(-(2**(W-1)));
  localparam logic signed [W-1:0] INIT_VAL = W'(INIT_PM);

  // One extra bit of headroom so the clamp sees the true sum instead of a wrapped one.
  function automatic logic signed [W-1:0] satadd(input logic signed [W-1:0] a,
                                                 input logic [1:0]          bm);
    logic signed [W:0] sum;
    sum = $signed({a[W-1], a}) + $signed({{(W-1){1'b0}}, bm});
    if (sum > SUM_MAX)
      return $signed(SUM_MAX[W-1:0]);
    else if (sum < SUM_MIN)
      return $signed(SUM_MIN[W-1:0]);
    else
      return $signed(sum[W-1:0]);
  endfunction

  function automatic logic [1:0] branch_bm(input logic [1:0] s,
                                           input logic       u,
                                           input logic [1:0] rx);
    logic [1:0] diff;
    diff = rx ^ {u ^ s[0], u ^ s[1] ^ s[0]};
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  logic signed [W-1:0] pm_p1 [4];
  logic [3:0]          dec_p1;
  logic [1:0]          min_state_p1;
  logic                vld_p1;

  logic signed [W-1:0] src_p0  [4];
  logic signed [W-1:0] new_p0  [4];
  logic signed [W-1:0] norm_p0 [4];
  logic signed [W-1:0] min_pm_p0;
  logic [3:0]          dec_p0;
  logic [1:0]          min_state_p0;

  // Stage p0: source metric select, ACS and normalization
  always_comb begin
    for (int n = 0; n < 4; n++)
      src_p0[n] = bus.start ? ((n == 0) ? '0 : INIT_VAL) : pm_p1[n];
  end

  for (genvar g = 0; g < 4; g++) begin : g_acs
    localparam int   P0 = (g % 2) * 2;
    localparam int   P1 = P0 + 1;
    localparam logic U  = 1'(g / 2);

    logic signed [W-1:0] cand0;
    logic signed [W-1:0] cand1;

    assign cand0     = satadd(src_p0[P0], branch_bm(2'(P0), U, bus.sym));
    assign cand1     = satadd(src_p0[P1], branch_bm(2'(P1), U, bus.sym));
    assign dec_p0[g] = (cand1 < cand0);
    assign new_p0[g] = dec_p0[g] ? cand1 : cand0;

    assign bus.pm[g*W +: W] = pm_p1[g];
  end

  always_comb begin
    min_pm_p0    = new_p0[0];
    min_state_p0 = 2'd0;
    for (int n = 1; n < 4; n++) begin
      if (new_p0[n] < min_pm_p0) begin
        min_pm_p0    = new_p0[n];
        min_state_p0 = 2'(n);
      end
    end
    for (int n = 0; n < 4; n++)
      norm_p0[n] = new_p0[n] - min_pm_p0;
  end

  // Stage p1: registered metrics and decisions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pm_p1[0]     <= '0;
      for (int n = 1; n < 4; n++)
        pm_p1[n]   <= INIT_VAL;
      dec_p1       <= '0;
      min_state_p1 <= '0;
      vld_p1       <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        for (int n = 0; n < 4; n++)
          pm_p1[n] <= norm_p0[n];
        dec_p1       <= dec_p0;
        min_state_p1 <= min_state_p0;
      end else if (bus.start) begin
        for (int n = 0; n < 4; n++)
          pm_p1[n] <= src_p0[n];
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.dec       = dec_p1;
  assign bus.min_state = min_state_p1;
endmodule

// File: tb/tb_viterbi_acs4.sv
// Directed bench for viterbi_acs4: reset, single steps, saturation, a clean
// encoded stream, start handling and asynchronous reset.
module tb_viterbi_acs4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  viterbi_acs4_if #(.W(6)) bus_a ();
  viterbi_acs4_if #(.W(6)) bus_b ();

  viterbi_acs4 #(.W(6), .INIT_PM(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  viterbi_acs4 #(.W(6), .INIT_PM(30)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  function automatic logic [23:0] pk(input int a3, input int a2, input int a1, input int a0);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  task automatic step_a(input logic v, input logic st, input logic [1:0] s);
    bus_a.in_valid = v;
    bus_a.start    = st;
    bus_a.sym      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus_a.out_valid); end
    n_checks++; if (bus_a.dec !== 4'b0000) begin n_fail++; $display("FAIL reset_dec: got %b want 0000", bus_a.dec); end
    n_checks++; if (bus_a.min_state !== 2'd0) begin n_fail++; $display("FAIL reset_min_state: got %0d want 0", bus_a.min_state); end
    n_checks++; if (bus_a.pm !== pk(16, 16, 16, 0)) begin n_fail++; $display("FAIL reset_pm: got %h want %h", bus_a.pm, pk(16, 16, 16, 0)); end
    n_checks++; if (bus_b.pm !== pk(30, 30, 30, 0)) begin n_fail++; $display("FAIL reset_pm_b: got %h want %h", bus_b.pm, pk(30, 30, 30, 0)); end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    bus_b.in_valid = 1'b1;
    bus_b.start    = 1'b0;
    bus_b.sym      = 2'b00;
    @(posedge clk);
    #1;
    bus_b.in_valid = 1'b0;
    n_checks++; if (bus_b.out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_out_valid: got %b want 1", bus_b.out_valid); end
    n_checks++; if (bus_b.dec[0] !== 1'b0) begin n_fail++; $display("FAIL sat_dec0: got %b want 0", bus_b.dec[0]); end
    n_checks++; if (bus_b.pm !== pk(31, 2, 31, 0)) begin n_fail++; $display("FAIL sat_pm: got %h want %h", bus_b.pm, pk(31, 2, 31, 0)); end
    n_checks++; if (bus_b.min_state !== 2'd0) begin n_fail++; $display("FAIL sat_min_state: got %0d want 0", bus_b.min_state); end
  endtask

  task automatic test_first_steps;
    step_a(1'b1, 1'b0, 2'b00);
    n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL step1_out_valid: got %b want 1", bus_a.out_valid); end
    n_checks++; if (bus_a.pm !== pk(17, 2, 17, 0)) begin n_fail++; $display("FAIL step1_pm: got %h want %h", bus_a.pm, pk(17, 2, 17, 0)); end
    n_checks++; if (bus_a.dec !== 4'b0000) begin n_fail++; $display("FAIL step1_dec: got %b want 0000", bus_a.dec); end
    n_checks++; if (bus_a.min_state !== 2'd0) begin n_fail++; $display("FAIL step1_min_state: got %0d want 0", bus_a.min_state); end
    step_a(1'b1, 1'b0, 2'b11);
    n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL step2_out_valid: got %b want 1", bus_a.out_valid); end
    n_checks++; if (bus_a.pm !== pk(3, 0, 3, 2)) begin n_fail++; $display("FAIL step2_pm: got %h want %h", bus_a.pm, pk(3, 0, 3, 2)); end
    n_checks++; if (bus_a.dec !== 4'b0000) begin n_fail++; $display("FAIL step2_dec: got %b want 0000", bus_a.dec); end
    n_checks++; if (bus_a.min_state !== 2'd2) begin n_fail++; $display("FAIL step2_min_state: got %0d want 2", bus_a.min_state); end
  endtask

  task automatic test_hold;
    step_a(1'b0, 1'b0, 2'b01);
    n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_out_valid: got %b want 0", bus_a.out_valid); end
    n_checks++; if (bus_a.pm !== pk(3, 0, 3, 2)) begin n_fail++; $display("FAIL hold_pm: got %h want %h", bus_a.pm, pk(3, 0, 3, 2)); end
    n_checks++; if (bus_a.min_state !== 2'd2) begin n_fail++; $display("FAIL hold_min_state: got %0d want 2", bus_a.min_state); end
  endtask

  task automatic test_decode;
    logic [1:0] syms [6];
    logic [1:0] states [6];
    logic [5:0] true_pm;
    syms   = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    states = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      step_a(1'b1, (i == 0), syms[i]);
      true_pm = bus_a.pm[states[i]*6 +: 6];
      n_checks++; if (bus_a.min_state !== states[i]) begin n_fail++; $display("FAIL decode_min_state[%0d]: got %0d want %0d", i, bus_a.min_state, states[i]); end
      n_checks++; if (true_pm !== 6'd0) begin n_fail++; $display("FAIL decode_true_pm[%0d]: got %0d want 0", i, true_pm); end
      if (i == 2) begin
        n_checks++; if (bus_a.dec !== 4'b1111) begin n_fail++; $display("FAIL decode_dec[2]: got %b want 1111", bus_a.dec); end
      end
    end
    n_checks++; if (bus_a.pm !== pk(3, 2, 3, 0)) begin n_fail++; $display("FAIL decode_final_pm: got %h want %h", bus_a.pm, pk(3, 2, 3, 0)); end
    n_checks++; if (bus_a.dec !== 4'b1111) begin n_fail++; $display("FAIL decode_final_dec: got %b want 1111", bus_a.dec); end
  endtask

  task automatic test_start_idle;
    step_a(1'b0, 1'b1, 2'b11);
    n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL start_idle_out_valid: got %b want 0", bus_a.out_valid); end
    n_checks++; if (bus_a.pm !== pk(16, 16, 16, 0)) begin n_fail++; $display("FAIL start_idle_pm: got %h want %h", bus_a.pm, pk(16, 16, 16, 0)); end
    n_checks++; if (bus_a.dec !== 4'b1111) begin n_fail++; $display("FAIL start_idle_dec: got %b want 1111", bus_a.dec); end
    n_checks++; if (bus_a.min_state !== 2'd0) begin n_fail++; $display("FAIL start_idle_min_state: got %0d want 0", bus_a.min_state); end
    step_a(1'b1, 1'b0, 2'b00);
    n_checks++; if (bus_a.pm !== pk(17, 2, 17, 0)) begin n_fail++; $display("FAIL start_idle_step_pm: got %h want %h", bus_a.pm, pk(17, 2, 17, 0)); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] syms [3];
    logic [1:0] states [3];
    syms   = '{2'b11, 2'b01, 2'b00};
    states = '{2'd2, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      step_a(1'b1, (i == 0), syms[i]);
      n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b want 1", i, bus_a.out_valid); end
      n_checks++; if (bus_a.min_state !== states[i]) begin n_fail++; $display("FAIL b2b_min_state[%0d]: got %0d want %0d", i, bus_a.min_state, states[i]); end
    end
    step_a(1'b1, 1'b1, 2'b00);
    n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL restart_out_valid: got %b want 1", bus_a.out_valid); end
    n_checks++; if (bus_a.pm !== pk(17, 2, 17, 0)) begin n_fail++; $display("FAIL restart_pm: got %h want %h", bus_a.pm, pk(17, 2, 17, 0)); end
    n_checks++; if (bus_a.dec !== 4'b0000) begin n_fail++; $display("FAIL restart_dec: got %b want 0000", bus_a.dec); end
    n_checks++; if (bus_a.min_state !== 2'd0) begin n_fail++; $display("FAIL restart_min_state: got %0d want 0", bus_a.min_state); end
    step_a(1'b1, 1'b0, 2'b11);
    n_checks++; if (bus_a.pm !== pk(3, 0, 3, 2)) begin n_fail++; $display("FAIL restart_next_pm: got %h want %h", bus_a.pm, pk(3, 0, 3, 2)); end
  endtask

  task automatic test_async_reset;
    bus_a.in_valid = 1'b1;
    bus_a.start    = 1'b0;
    bus_a.sym      = 2'b10;
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_out_valid: got %b want 0", bus_a.out_valid); end
    n_checks++; if (bus_a.pm !== pk(16, 16, 16, 0)) begin n_fail++; $display("FAIL async_pm: got %h want %h", bus_a.pm, pk(16, 16, 16, 0)); end
    n_checks++; if (bus_a.min_state !== 2'd0) begin n_fail++; $display("FAIL async_min_state: got %0d want 0", bus_a.min_state); end
    n_checks++; if (bus_a.dec !== 4'b0000) begin n_fail++; $display("FAIL async_dec: got %b want 0000", bus_a.dec); end
    @(posedge clk);
    #1;
    n_checks++; if (bus_a.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_held_out_valid: got %b want 0", bus_a.out_valid); end
    rst_n = 1'b1;
    step_a(1'b1, 1'b0, 2'b00);
    n_checks++; if (bus_a.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_out_valid: got %b want 1", bus_a.out_valid); end
    n_checks++; if (bus_a.pm !== pk(17, 2, 17, 0)) begin n_fail++; $display("FAIL post_reset_pm: got %h want %h", bus_a.pm, pk(17, 2, 17, 0)); end
    n_checks++; if (bus_a.min_state !== 2'd0) begin n_fail++; $display("FAIL post_reset_min_state: got %0d want 0", bus_a.min_state); end
    bus_a.in_valid = 1'b0;
  endtask

  initial begin
    bus_a.in_valid = 1'b0;
    bus_a.start    = 1'b0;
    bus_a.sym      = 2'b00;
    bus_b.in_valid = 1'b0;
    bus_b.start    = 1'b0;
    bus_b.sym      = 2'b00;
    test_reset();
    test_saturation();
    test_first_steps();
    test_hold();
    test_decode();
    test_start_idle();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
